repeat_nfa_top: RTL and testbench
=================================

Name: repeat_nfa_top

Overview:
- Streaming byte-level regex matcher built as a one-hot NFA.
- Detects the unanchored pattern (CH0 CH1 CH2){REP}, default "(abc){3}", in a byte stream.
- Consumes one payload byte per enabled clock.
- Sits at the top of the NFA matcher datapath; match feeds downstream flagging logic.

Parameters:
- REP, 3: number of consecutive repetitions of the 3-byte unit required for a match (legal range 1..16).
- CH0, 8'd97 ('a'): first byte of the repeated unit.
- CH1, 8'd98 ('b'): second byte of the repeated unit.
- CH2, 8'd99 ('c'): third byte of the repeated unit.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous reset, active-high (port name kept per codebase; reset asserted when reset_n=1).
- en  input  1  byte-valid/enable; payload consumed on a rising clk edge only when en=1.
- payload  input  8  input byte.
- match  output  1  registered; high when the last consumed byte completes REP consecutive units.

Behaviour:
- State: one-hot active vector st[1..3*REP]. Bit k means the last k consumed bytes equal the first k bytes of the unrolled pattern.
- Start state st[0] is implicitly always active (unanchored search), so a match may begin at any byte.
- Each rising clk edge with en=1 applies these updates in parallel:
  - st[k] <= st[k-1] & (payload == CH[(k-1) mod 3]), for k = 1..3*REP, with st[0] treated as 1.
  - match <= st[3*REP-1] & (payload == CH2).
- Overlapping matches are supported (all states update in parallel). A stream of N*3 units with N > REP gives one match pulse per unit from unit REP onward.
- en=0: state vector and match hold their values; payload is ignored.
- Latency: match rises at the clk edge that samples the final CH2 byte and stays high for one enabled cycle. It drops at the next enabled edge unless that byte completes another match (for REP>=1 this cannot occur on the very next byte).
- Reset (reset_n=1, asynchronous): st all 0, match=0 immediately, independent of clk.
  - While reset is held, no bytes are consumed.
  - Reset mid-pattern discards partial progress; matching restarts from scratch after release.
- A mismatching byte kills only the threads it breaks. A byte equal to CH0 always (re)starts a thread at st[1].
- Payload values 0 and any non-pattern byte simply fail all comparisons.
- No X-propagation dependence: before the first enabled edge after reset, match=0.

Test Plan:
- Reset then en=1, payload a,b,c,a,b,c,a,b,c,0x00 one per clk → match=0 through the 8th edge, match=1 after the 9th edge (sampled 'c'), match=0 after the 10th edge (0x00).
- en=1, stream "abcabc" then 0x00 → match never asserts (only 2 repetitions).
- en=1, stream "abcabcabcabc" → match=1 after edges 9 and 12 only; 0 after edges 10 and 11.
- en=1, stream "abcab" then en=0 for 3 clocks with payload=0xFF, then en=1 with "cabcabc" → match=1 after the final 'c'; no state change during en=0.
- en=1, stream "abcabca" then assert reset_n=1 asynchronously mid-cycle → match=0 immediately; after release, "bcabcabc" → no match, while "abcabcabc" → match after its 9th byte.
- en=1, stream "aabcabcabc" (a leading extra 'a') → match=1 after the 10th edge, showing the unanchored restart.

Source files
------------

// File: rtl/repeat_nfa_top.sv
// Streaming one-hot NFA matcher for the unanchored pattern (CH0 CH1 CH2){REP}.
// One byte is consumed per enabled clock; match is the final NFA state bit.
module repeat_nfa_top #(
    parameter int        REP = 3,
    parameter logic [7:0] CH0 = 8'd97,
    parameter logic [7:0] CH1 = 8'd98,
    parameter logic [7:0] CH2 = 8'd99
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [7:0] payload,
    output logic       match
);

    localparam int N = 3 * REP;

    logic       hit0;
    logic       hit1;
    logic       hit2;
    logic [N:1] want;
    logic [N:1] st;
    logic [N:1] st_next;

    assign hit0 = (payload == CH0);
    assign hit1 = (payload == CH1);
    assign hit2 = (payload == CH2);

    // want[k] is the comparison result for position k of the unrolled pattern.
    for (genvar k = 1; k <= N; k++) begin : g_want
        localparam int PHASE = (k - 1) % 3;
        if (PHASE == 0) begin : g_p0
            assign want[k] = hit0;
        end else if (PHASE == 1) begin : g_p1
            assign want[k] = hit1;
        end else begin : g_p2
            assign want[k] = hit2;
        end
    end

    // Shift every thread forward one position; the constant 1 is the
    // always-active start state that lets a match begin at any byte.
    always_comb begin
        st_next = {st[N-1:1], 1'b1} & want;
    end

    // reset_n is active-high despite its name.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            st <= '0;
        end else if (en) begin
            st <= st_next;
        end
    end

    // The last state is exactly "final CH2 of REP units just consumed".
    assign match = st[N];

endmodule

// File: tb/tb_repeat_nfa_top.sv
// Directed bench for repeat_nfa_top with the default "(abc){3}" pattern.
// A vector table covers the streams; hand-written sequences cover mid-cycle reset.
module tb_repeat_nfa_top;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic [7:0] payload;
    logic       match;

    repeat_nfa_top dut (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (en),
        .payload(payload),
        .match  (match)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] pl;
        logic       exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: match=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst, input logic e, input logic [7:0] pl, input logic exp);
        vec_t v;
        v.rst = rst;
        v.en  = e;
        v.pl  = pl;
        v.exp = exp;
        vecs.push_back(v);
    endtask

    // Bit i of hits is the expected match after the (i+1)-th byte of s.
    task automatic add_s(input string s, input logic [31:0] hits);
        for (int i = 0; i < s.len(); i++) begin
            add(1'b0, 1'b1, s[i], hits[i]);
        end
    endtask

    task automatic add_rst();
        add(1'b1, 1'b1, 8'h61, 1'b0);
    endtask

    task automatic step(input logic e, input logic [7:0] pl);
        @(negedge clk);
        en      = e;
        payload = pl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b1;
        en      = 1'b0;
        payload = 8'h00;
        #2;
        check("reset_state", match, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held", match, 1'b0);
        reset_n = 1'b0;

        // Basic three repetitions then a zero byte.
        add_rst();
        add_s("abcabcabc", 32'h100);
        add(1'b0, 1'b1, 8'h00, 1'b0);
        // Only two repetitions.
        add_rst();
        add_s("abcabc", 32'h0);
        add(1'b0, 1'b1, 8'h00, 1'b0);
        // Overlapping: four units, then en=0 holds the pulse.
        add_rst();
        add_s("abcabcabcabc", 32'h900);
        add(1'b0, 1'b0, 8'hFF, 1'b1);
        add(1'b0, 1'b0, 8'hFF, 1'b1);
        add(1'b0, 1'b1, 8'h61, 1'b0);
        // en=0 gap inside a pattern.
        add_rst();
        add_s("abcab", 32'h0);
        add(1'b0, 1'b0, 8'hFF, 1'b0);
        add(1'b0, 1'b0, 8'hFF, 1'b0);
        add(1'b0, 1'b0, 8'hFF, 1'b0);
        add_s("cabcabc", 32'h48);
        // Reset discards partial progress.
        add_rst();
        add_s("abcabca", 32'h0);
        add_rst();
        add_s("bcabcabc", 32'h0);
        add_rst();
        add_s("abcabcabc", 32'h100);
        // Leading extra 'a' restarts the thread.
        add_rst();
        add_s("aabcabcabc", 32'h200);

        foreach (vecs[i]) begin
            @(negedge clk);
            en      = vecs[i].en;
            payload = vecs[i].pl;
            if (vecs[i].rst) begin
                reset_n = 1'b1;
                #1;
                check($sformatf("async_rst_vec%0d", i), match, 1'b0);
            end
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), match, vecs[i].exp);
            reset_n = 1'b0;
        end

        // Mid-cycle reset while match is high drops it without a clock edge.
        reset_n = 1'b1;
        #2;
        reset_n = 1'b0;
        begin
            string s;
            s = "abcabcabc";
            for (int i = 0; i < s.len(); i++) begin
                step(1'b1, s[i]);
            end
        end
        check("pre_reset_match", match, 1'b1);
        #2;
        reset_n = 1'b1;
        #1;
        check("midcycle_reset", match, 1'b0);
        // Bytes presented while reset is held must not be consumed.
        step(1'b1, 8'h61);
        check("reset_hold_a", match, 1'b0);
        #2;
        reset_n = 1'b0;
        begin
            string s;
            s = "bcabcabc";
            for (int i = 0; i < s.len(); i++) begin
                step(1'b1, s[i]);
                check($sformatf("post_reset_byte%0d", i), match, 1'b0);
            end
        end
        step(1'b1, 8'h00);
        check("post_reset_tail", match, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
